multi_channel_debounce: RTL and testbench

MULTI_CHANNEL_DEBOUNCE -- requirements
Module: multi_channel_debounce

---
 rtl/multi_channel_debounce.sv | 210 +++++++++++++++++++++
 tb/tb_multi_channel_debounce.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_debounce.sv
// -----------------------------------------------------------------------------
// multi_channel_debounce
//   Debounces N raw asynchronous inputs. Every input is first brought into the
//   clock domain through a two-flop synchronizer. Two modes:
//     MUTEX=0 : each channel has its own timer; a channel's output follows its
//               synchronized input once the input has disagreed with the output
//               for C_T consecutive clocks.
//     MUTEX=1 : the channels form a mutually-exclusive group driven by one FSM
//               and one shared timer; at most one output bit is ever set, and a
//               change from one channel to another always passes through zero.
//
// Parameters
//   FCLK        system clock frequency in Hz
//   N           channel count (1..16)
//   DEBOUNCE_US debounce interval in microseconds
//   MUTEX       1 = group mode, 0 = independent per-channel mode
//
// Ports
//   i_clk_mhz   system clock
//   i_rst_mhz   asynchronous active-high reset
//   ei_inputs   raw asynchronous channel inputs
//   o_deb       debounced level per channel
//   o_press     one-cycle pulse in the first cycle o_deb[i] is high
//   o_release   one-cycle pulse in the first cycle o_deb[i] is low
//   o_conflict  registered flag: two or more synchronized inputs high (MUTEX=1)
// -----------------------------------------------------------------------------
module multi_channel_debounce #(
  parameter int unsigned FCLK        = 20000000,
  parameter int unsigned N           = 4,
  parameter int unsigned DEBOUNCE_US = 1000,
  parameter int unsigned MUTEX       = 1
) (
  input  logic         i_clk_mhz,
  input  logic         i_rst_mhz,
  input  logic [N-1:0] ei_inputs,
  output logic [N-1:0] o_deb,
  output logic [N-1:0] o_press,
  output logic [N-1:0] o_release,
  output logic         o_conflict
);

  localparam int unsigned C_T = FCLK / 1000000 * DEBOUNCE_US;
  localparam int unsigned TW  = (C_T > 1) ? $clog2(C_T) : 1;
  localparam int unsigned PW  = 5;
  localparam logic [TW-1:0] T_LAST = TW'(C_T - 1);

  // Elaboration-time parameter sanity
  generate
    if (C_T < 2) begin : g_bad_ct
      $error("multi_channel_debounce: debounce count C_T must be at least 2");
    end
    if ((N < 1) || (N > 16)) begin : g_bad_n
      $error("multi_channel_debounce: N must be in 1..16");
    end
  endgenerate

  // Number of set bits in a channel vector
  function automatic logic [PW-1:0] popcnt(input logic [N-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(N); i++) begin
      c = c + PW'(v[i]);
    end
    return c;
  endfunction

  logic [N-1:0] sync1_q;
  logic [N-1:0] sync_q;
  logic [N-1:0] deb_q;
  logic [N-1:0] press_q;
  logic [N-1:0] release_q;
  logic         conflict_q;

  // Two-flop synchronizer and the group conflict flag
  always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
    if (i_rst_mhz) begin
      sync1_q    <= '0;
      sync_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      sync1_q    <= ei_inputs;
      sync_q     <= sync1_q;
      conflict_q <= (MUTEX != 0) && (popcnt(sync_q) >= PW'(2));
    end
  end

  generate
    if (MUTEX == 0) begin : g_indep
      logic [TW-1:0] cnt_q [N];
      logic [TW-1:0] cnt_d [N];
      logic [N-1:0]  deb_d;

      // Per-channel timer: runs only while input and output disagree
      always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < int'(N); i++) begin
          cnt_d[i] = cnt_q[i];
          if (sync_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == T_LAST) begin
            deb_d[i] = sync_q[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + TW'(1);
          end
        end
      end

      // Pulses are formed from the next level so they land with the new level
      always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
        if (i_rst_mhz) begin
          for (int i = 0; i < int'(N); i++) begin
            cnt_q[i] <= '0;
          end
          deb_q     <= '0;
          press_q   <= '0;
          release_q <= '0;
        end else begin
          for (int i = 0; i < int'(N); i++) begin
            cnt_q[i] <= cnt_d[i];
          end
          deb_q     <= deb_d;
          press_q   <= deb_d & ~deb_q;
          release_q <= ~deb_d & deb_q;
        end
      end
    end else begin : g_mutex
      // One-hot encoding leaves spare codes that recover to ST_WAIT
      typedef enum logic [3:0] {
        ST_WAIT  = 4'b0001,
        ST_QUAL  = 4'b0010,
        ST_HOLD  = 4'b0100,
        ST_LEAVE = 4'b1000
      } state_t;

      state_t        state_q;
      logic [TW-1:0] timer_q;
      logic [N-1:0]  cand_q;

      // Group FSM; press/release are set on the transitions that move o_deb
      always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
        if (i_rst_mhz) begin
          state_q   <= ST_WAIT;
          timer_q   <= '0;
          cand_q    <= '0;
          deb_q     <= '0;
          press_q   <= '0;
          release_q <= '0;
        end else begin
          press_q   <= '0;
          release_q <= '0;
          case (state_q)
            ST_WAIT: begin
              timer_q <= '0;
              if (popcnt(sync_q) <= PW'(1)) begin
                cand_q  <= sync_q;
                state_q <= ST_QUAL;
              end
            end
            ST_QUAL: begin
              if (sync_q != cand_q) begin
                state_q <= ST_WAIT;
                timer_q <= '0;
              end else if (timer_q == T_LAST) begin
                deb_q   <= cand_q;
                press_q <= cand_q;
                state_q <= ST_HOLD;
                timer_q <= '0;
              end else begin
                timer_q <= timer_q + TW'(1);
              end
            end
            ST_HOLD: begin
              timer_q <= '0;
              if (sync_q != deb_q) begin
                state_q <= ST_LEAVE;
              end
            end
            ST_LEAVE: begin
              if (sync_q == deb_q) begin
                state_q <= ST_HOLD;
                timer_q <= '0;
              end else if (timer_q == T_LAST) begin
                deb_q     <= '0;
                release_q <= deb_q;
                state_q   <= ST_WAIT;
                timer_q   <= '0;
              end else begin
                timer_q <= timer_q + TW'(1);
              end
            end
            default: begin
              state_q   <= ST_WAIT;
              timer_q   <= '0;
              cand_q    <= '0;
              deb_q     <= '0;
              release_q <= deb_q;
            end
          endcase
        end
      end
    end
  endgenerate

  assign o_deb      = deb_q;
  assign o_press    = press_q;
  assign o_release  = release_q;
  assign o_conflict = conflict_q;

endmodule

// File: tb/tb_multi_channel_debounce.sv
// -----------------------------------------------------------------------------
// tb_multi_channel_debounce
//   Drives one independent-mode and one group-mode instance (C_T=4, N=4) from
//   the same input vector and compares every cycle against a behavioural model
//   expressed as "consecutive cycles of disagreement" counts, plus directed
//   timing checks for the key scenarios.
// -----------------------------------------------------------------------------
module tb_multi_channel_debounce;

  localparam int CT = 4;
  localparam int M_WAIT  = 0;
  localparam int M_QUAL  = 1;
  localparam int M_HOLD  = 2;
  localparam int M_LEAVE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] ei  = 4'b0000;

  logic [3:0] d0_deb, d0_press, d0_release;
  logic       d0_conflict;
  logic [3:0] d1_deb, d1_press, d1_release;
  logic       d1_conflict;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [3:0] s1, s2;
  logic [3:0] m0_deb, m0_prs, m0_rel;
  int         run0 [4];
  logic [3:0] m1_deb, m1_prs, m1_rel, cand;
  int         mode, run1;
  logic       m_cf;

  always #5 clk = ~clk;

  multi_channel_debounce #(
    .FCLK(4000000), .N(4), .DEBOUNCE_US(1), .MUTEX(0)
  ) dut_ind (
    .i_clk_mhz (clk),
    .i_rst_mhz (rst),
    .ei_inputs (ei),
    .o_deb     (d0_deb),
    .o_press   (d0_press),
    .o_release (d0_release),
    .o_conflict(d0_conflict)
  );

  multi_channel_debounce #(
    .FCLK(4000000), .N(4), .DEBOUNCE_US(1), .MUTEX(1)
  ) dut_mx (
    .i_clk_mhz (clk),
    .i_rst_mhz (rst),
    .ei_inputs (ei),
    .o_deb     (d1_deb),
    .o_press   (d1_press),
    .o_release (d1_release),
    .o_conflict(d1_conflict)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    s1 = '0; s2 = '0;
    m0_deb = '0; m0_prs = '0; m0_rel = '0;
    for (int i = 0; i < 4; i++) run0[i] = 0;
    m1_deb = '0; m1_prs = '0; m1_rel = '0; cand = '0;
    mode = M_WAIT; run1 = 0; m_cf = 1'b0;
  endtask

  // One clock edge of the reference behaviour, x = raw input seen at the edge
  task automatic model_edge(input logic [3:0] x);
    logic [3:0] old0, old1;
    old0 = m0_deb;
    old1 = m1_deb;
    // Independent: flip after CT consecutive edges of disagreement
    for (int i = 0; i < 4; i++) begin
      if (s2[i] != m0_deb[i]) begin
        run0[i]++;
        if (run0[i] == CT) begin
          m0_deb[i] = s2[i];
          run0[i] = 0;
        end
      end else begin
        run0[i] = 0;
      end
    end
    m0_prs = m0_deb & ~old0;
    m0_rel = ~m0_deb & old0;
    // Group: candidate needs CT stable edges, leaving needs CT edges away
    case (mode)
      M_WAIT: if ($countones(s2) <= 1) begin cand = s2; mode = M_QUAL; run1 = 0; end
      M_QUAL: begin
        if (s2 != cand) mode = M_WAIT;
        else begin
          run1++;
          if (run1 == CT) begin m1_deb = cand; mode = M_HOLD; end
        end
      end
      M_HOLD: if (s2 != m1_deb) begin mode = M_LEAVE; run1 = 0; end
      default: begin
        if (s2 == m1_deb) mode = M_HOLD;
        else begin
          run1++;
          if (run1 == CT) begin m1_deb = '0; mode = M_WAIT; end
        end
      end
    endcase
    m1_prs = m1_deb & ~old1;
    m1_rel = ~m1_deb & old1;
    m_cf = ($countones(s2) >= 2);
    s2 = s1;
    s1 = x;
  endtask

  task automatic compare_all();
    check("ind_deb",      32'(d0_deb),      32'(m0_deb));
    check("ind_press",    32'(d0_press),    32'(m0_prs));
    check("ind_release",  32'(d0_release),  32'(m0_rel));
    check("ind_conflict", 32'(d0_conflict), 32'(0));
    check("mx_deb",       32'(d1_deb),      32'(m1_deb));
    check("mx_press",     32'(d1_press),    32'(m1_prs));
    check("mx_release",   32'(d1_release),  32'(m1_rel));
    check("mx_conflict",  32'(d1_conflict), 32'(m_cf));
    check("mx_onehot",    32'($countones(d1_deb) <= 1), 32'(1));
  endtask

  task automatic cycle(input logic [3:0] x);
    ei = x;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(x);
    #1;
    compare_all();
  endtask

  task automatic hold(input logic [3:0] x, input int n);
    for (int k = 0; k < n; k++) cycle(x);
  endtask

  initial begin
    int edge_n;
    int rel_at, prs_at;
    logic [3:0] acc, v;

    // Reset asserted with no clock edge
    #1 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    hold(4'b0000, 3);
    rst = 1'b0;
    hold(4'b0000, 12);

    // Independent press lands on the 6th edge after the change
    edge_n = 0;
    for (int e = 1; e <= 10; e++) begin
      cycle(4'b0001);
      if (d0_press == 4'b0001 && edge_n == 0) edge_n = e;
    end
    check("ind_press_edge", 32'(edge_n), 32'(6));
    hold(4'b0001, 10);
    edge_n = 0;
    for (int e = 1; e <= 10; e++) begin
      cycle(4'b0000);
      if (d0_release == 4'b0001 && edge_n == 0) edge_n = e;
    end
    check("ind_release_edge", 32'(edge_n), 32'(6));
    hold(4'b0000, 12);

    // Short glitch on bit 2 is swallowed
    acc = '0;
    for (int e = 0; e < 3; e++) begin
      cycle(4'b0100);
      acc = acc | d0_deb | d0_press | d0_release;
    end
    for (int e = 0; e < 10; e++) begin
      cycle(4'b0000);
      acc = acc | d0_deb | d0_press | d0_release;
    end
    check("ind_glitch", 32'(acc), 32'(0));

    // Conflict rises on the 3rd edge; then a single channel is accepted
    edge_n = 0;
    for (int e = 1; e <= 8; e++) begin
      cycle(4'b0011);
      if (d1_conflict && edge_n == 0) edge_n = e;
    end
    check("mx_conflict_edge", 32'(edge_n), 32'(3));
    hold(4'b0011, 10);
    check("mx_conflict_deb", 32'(d1_deb), 32'(0));
    hold(4'b0010, 20);
    check("mx_accept_0010", 32'(d1_deb), 32'(4'b0010));
    hold(4'b0000, 20);

    // Accept 0100, short drop keeps it, full drop releases
    hold(4'b0100, 20);
    hold(4'b0000, 2);
    hold(4'b0100, 10);
    check("mx_hold_0100", 32'(d1_deb), 32'(4'b0100));
    hold(4'b0000, 20);
    check("mx_released", 32'(d1_deb), 32'(0));

    // Direct one-hot to one-hot goes through zero, release first
    hold(4'b1000, 20);
    rel_at = -1; prs_at = -1;
    for (int e = 1; e <= 30; e++) begin
      cycle(4'b0001);
      if (d1_release == 4'b1000 && rel_at < 0) rel_at = e;
      if (d1_press == 4'b0001 && prs_at < 0) prs_at = e;
    end
    check("mx_switch_seen", 32'((rel_at > 0) && (prs_at > 0)), 32'(1));
    check("mx_switch_order", 32'(rel_at < prs_at), 32'(1));

    // Reset between edges while holding
    hold(4'b0100, 30);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("rst_mid_ind_deb", 32'(d0_deb), 32'(0));
    check("rst_mid_mx_deb",  32'(d1_deb), 32'(0));
    check("rst_mid_pulses",  32'(d0_press | d0_release | d1_press | d1_release), 32'(0));
    hold(4'b0100, 3);
    rst = 1'b0;
    hold(4'b0100, 20);
    check("rst_requal_mx", 32'(d1_deb), 32'(4'b0100));

    // Randomized segments
    v = 4'b0000;
    for (int s = 0; s < 200; s++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4)      v = 4'(1 << r);
      else if (r < 6) v = 4'b0000;
      else if (r < 8) v = 4'($urandom_range(0, 15));
      else            v = v ^ 4'(1 << $urandom_range(0, 3));
      hold(v, int'($urandom_range(1, 12)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
